stack_unit: RTL
===============

Name: stack_unit

Overview:
Hardware data stack that sits downstream of the control unit in the execute stage of the CPU. It consumes the psh/pop strobes and the execute-phase enable, pushes operand data onto an internal LIFO and returns popped data to the datapath. It tracks the stack pointer and reports full/empty conditions. It also keeps sticky overflow and underflow errors for the sequencer.

Parameters:
DATA_W, 16, width of one stack entry (matches the 16-bit datapath)
DEPTH, 16, number of entries; must be a power of two, at least 2
SP_W, 5, stack pointer width; must equal log2(DEPTH)+1 so the pointer can hold 0..DEPTH

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
en  input  1  execute-phase strobe; psh/pop are sampled only when en=1
psh  input  1  push request from the control unit
pop  input  1  pop request from the control unit
data_in  input  DATA_W  value to push
clr_err  input  1  synchronous clear of the sticky error flags
data_out  output  DATA_W  registered popped value
pop_vld  output  1  one-cycle pulse; data_out was updated this cycle
sp  output  SP_W  current entry count, 0..DEPTH
empty  output  1  sp==0 (combinational from sp)
full  output  1  sp==DEPTH (combinational from sp)
ovf  output  1  sticky: a push was attempted while full
unf  output  1  sticky: a pop was attempted while empty

Behaviour:
- Reset (rst=0, asynchronous):
  - sp=0, data_out=0, pop_vld=0, ovf=0, unf=0.
  - Memory contents are undefined and are not cleared.
- en=0: no state change; pop_vld=0 on the next edge. psh/pop are ignored.
- Push (en=1, psh=1, pop=0):
  - Not full: mem[sp]<=data_in, sp<=sp+1.
  - Full: no write, sp unchanged, ovf<=1.
- Pop (en=1, pop=1, psh=0):
  - Not empty: data_out<=mem[sp-1], sp<=sp-1, pop_vld<=1. Latency is 1 cycle from the sampling edge.
  - Empty: data_out unchanged, pop_vld=0, unf<=1.
- Swap (en=1, psh=1, pop=1):
  - Not empty: data_out<=old mem[sp-1], mem[sp-1]<=data_in, pop_vld<=1, sp unchanged. Read-before-write is mandatory.
  - Empty: data_in is written to mem[0], sp<=1, pop_vld=0, no error flag.
- pop_vld is high for exactly one cycle per successful pop or swap. Back-to-back operations on consecutive cycles are supported.
- Errors:
  - ovf and unf hold until clr_err=1 or reset.
  - If clr_err and a new error occur on the same edge, the new error wins and the flag stays 1.
- Arithmetic: sp never wraps. It saturates logically because a push at DEPTH and a pop at 0 are suppressed.
- A reset in the middle of a sequence aborts it; the next operation after reset sees an empty stack.

Optional Feature:
STACK_HLT_REQ_EN
- Defined: adds output port err_hlt (1 bit), err_hlt = ovf | unf. It is wired by the top level into the halt path, so the CPU freezes the PC on a stack fault.
- Not defined: the err_hlt port does not exist. Errors are visible only through ovf/unf.

Test Plan:
- Reset with sp=3 and ovf=1, pulse rst=0 asynchronously mid-cycle -> immediately sp=0, empty=1, ovf=0, unf=0, data_out=0.
- Push 0x1111, 0x2222, 0x3333 (en=1), then pop three times -> data_out=0x3333, 0x2222, 0x1111, each with a one-cycle pop_vld; finally sp=0, empty=1.
- Push 16 values 0x0000..0x000F, then push 0xBEEF -> full=1, sp=16, ovf=1. Then pop -> data_out=0x000F (0xBEEF was not stored).
- From empty, pop -> unf=1, pop_vld=0, data_out unchanged. Assert clr_err together with another pop from empty -> unf stays 1. clr_err alone -> unf=0.
- Push 0x00AA, then swap with data_in=0x0055 -> data_out=0x00AA, pop_vld=1, sp=1. Then pop -> data_out=0x0055, sp=0.
- Hold psh=1 with en=0 for 5 cycles -> sp unchanged, pop_vld=0. With STACK_HLT_REQ_EN defined, force an overflow -> err_hlt=1 until clr_err.

Source files
------------

// File: rtl/stack_unit.sv
// stack_unit -- execute-stage hardware data stack (LIFO).
//
// Pushes operand data onto an internal memory. Pops return data through a
// registered output with a one-cycle pop_vld pulse. Also tracks the entry
// count and keeps sticky overflow/underflow flags.
//
// Optional build macro: STACK_HLT_REQ_EN
//   When defined, adds err_hlt = ovf | unf for the CPU halt path.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous, active-low reset
//   en       execute-phase strobe; psh/pop are sampled only when en=1
//   psh      push request (psh & pop together = swap top of stack)
//   pop      pop request
//   data_in  value to push / swap in
//   clr_err  synchronous clear of ovf/unf (a new error on the same edge wins)
//   data_out registered popped value
//   pop_vld  one-cycle pulse when data_out was updated
//   sp       entry count, 0..DEPTH
//   empty    sp == 0
//   full     sp == DEPTH
//   ovf      sticky: push attempted while full
//   unf      sticky: pop attempted while empty
//   err_hlt  (STACK_HLT_REQ_EN only) ovf | unf
module stack_unit #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int SP_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              psh,
  input  logic              pop,
  input  logic [DATA_W-1:0] data_in,
  input  logic              clr_err,
  output logic [DATA_W-1:0] data_out,
  output logic              pop_vld,
  output logic [SP_W-1:0]   sp,
  output logic              empty,
  output logic              full,
  output logic              ovf,
`ifdef STACK_HLT_REQ_EN
  output logic              unf,
  output logic              err_hlt
`else
  output logic              unf
`endif
);

  localparam int AW = SP_W - 1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic          do_push, do_pop, do_swap, swap_empty;
  logic          ovf_set, unf_set;
  logic          we;
  logic [AW-1:0] sp_idx, top_idx, wr_idx;

  assign empty = (sp == '0);
  assign full  = (sp == SP_W'(DEPTH));

`ifdef STACK_HLT_REQ_EN
  assign err_hlt = ovf | unf;
`endif

  always_comb begin
    do_push    = en & psh & ~pop & ~full;
    do_pop     = en & pop & ~psh & ~empty;
    do_swap    = en & psh & pop & ~empty;
    swap_empty = en & psh & pop & empty;
    ovf_set    = en & psh & ~pop & full;
    unf_set    = en & pop & ~psh & empty;
    sp_idx     = AW'(sp);
    top_idx    = AW'(sp - SP_W'(1));
    we         = do_push | do_swap | swap_empty;
    // A swap on an empty stack behaves like a push into slot 0 (sp_idx == 0).
    wr_idx     = do_swap ? top_idx : sp_idx;
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) mem[wr_idx] <= data_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp       <= '0;
      data_out <= '0;
      pop_vld  <= 1'b0;
      ovf      <= 1'b0;
      unf      <= 1'b0;
    end else begin
      pop_vld <= do_pop | do_swap;
      // Non-blocking read of the old top gives read-before-write on a swap.
      if (do_pop | do_swap) data_out <= mem[top_idx];

      if (do_push | swap_empty) sp <= sp + SP_W'(1);
      else if (do_pop)          sp <= sp - SP_W'(1);

      if (ovf_set)      ovf <= 1'b1;
      else if (clr_err) ovf <= 1'b0;
      if (unf_set)      unf <= 1'b1;
      else if (clr_err) unf <= 1'b0;
    end
  end

endmodule
